// File: rtl/param_sync_fifo.sv
// Parameterised synchronous FIFO with programmable almost-full/empty thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read port.
module param_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                full_q, empty_q, af_q, ae_q;
    logic                ovf_q, ovf_d, udf_q, udf_d;
    logic                wr_acc, rd_acc;

    always_comb begin
        wr_acc   = wr_en & ~full_q;
        rd_acc   = rd_en & ~empty_q;
        wr_ptr_d = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_acc};
        rd_ptr_d = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_acc};
        // Wrap-bit pointers make the difference the occupancy, 0..DEPTH.
        count_d  = wr_ptr_d - rd_ptr_d;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (wr_en && full_q) ovf_d = 1'b1;
        else if (clr_err)    ovf_d = 1'b0;
        if (rd_en && empty_q) udf_d = 1'b1;
        else if (clr_err)     udf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == FULL_CNT);
            empty_q  <= (count_d == '0);
            af_q     <= (count_d >= af_thresh);
            ae_q     <= (count_d <= ae_thresh);
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= data_in;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out = empty_q ? '0 : mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign rd_valid = ~empty_q;
`else
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  rvalid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_acc;
            if (rd_acc) dout_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
    end

    assign data_out = dout_q;
    assign rd_valid = rvalid_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo (registered read mode) against a queue-based reference model.
module tb_param_sync_fifo;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [AW:0]   af_thresh = 5'd12, ae_thresh = 5'd4;
    logic [DW-1:0] data_out;
    logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [AW:0]   count;

    always #5 clk = ~clk;

    param_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out), .rd_valid(rd_valid), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_dout;
    logic          exp_valid, exp_ovf, exp_udf;

    task automatic model_reset();
        mq.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, return #1 after the edge with inputs idle.
    task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
        bit wacc, racc;
        wr_en = w; rd_en = r; data_in = d; clr_err = c;
        wacc = w && (mq.size() < DEPTH);
        racc = r && (mq.size() > 0);
        if (w && mq.size() == DEPTH) exp_ovf = 1'b1;
        else if (c)                  exp_ovf = 1'b0;
        if (r && mq.size() == 0)     exp_udf = 1'b1;
        else if (c)                  exp_udf = 1'b0;
        @(posedge clk);
        exp_valid = racc;
        if (racc) exp_dout = mq.pop_front();
        if (wacc) mq.push_back(d);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if ({full, empty, almost_full, almost_empty} !== 4'b0101) begin bad++; $display("FAIL reset_flags: got %b want 0101", {full, empty, almost_full, almost_empty}); end
        total++; if ({overflow, underflow, rd_valid} !== 3'b000) begin bad++; $display("FAIL reset_err_valid: got %b want 000", {overflow, underflow, rd_valid}); end
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_dout: got %0h want 0", data_out); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        model_reset();
    endtask

    task automatic test_fill();
        af_thresh = 5'd12; ae_thresh = 5'd4;
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, 1'b0, 8'(i), 1'b0);
            total++; if (count !== 5'(i + 1)) begin bad++; $display("FAIL fill_count: got %0d want %0d", count, i + 1); end
            total++; if (almost_full !== (i + 1 >= 12)) begin bad++; $display("FAIL fill_af[%0d]: got %b want %b", i, almost_full, (i + 1 >= 12)); end
            total++; if (full !== (i == DEPTH - 1)) begin bad++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, (i == DEPTH - 1)); end
        end
    endtask

    task automatic test_overflow_drain();
        cyc(1'b1, 1'b0, 8'hAA, 1'b0);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
        total++; if (count !== 5'd16) begin bad++; $display("FAIL ovf_count: got %0d want 16", count); end
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, 1'b1, 8'h00, 1'b0);
            total++; if (rd_valid !== 1'b1 || data_out !== 8'(i)) begin bad++; $display("FAIL drain[%0d]: got v=%b d=%0h want v=1 d=%0h", i, rd_valid, data_out, i); end
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL valid_pulse: got %b want 0", rd_valid); end
        total++; if (overflow !== 1'b1 || empty !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got ovf=%b empty=%b want 1 1", overflow, empty); end
    endtask

    task automatic test_underflow();
        logic [DW-1:0] prev;
        prev = data_out;
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL udf_set: got %b want 1", underflow); end
        total++; if (count !== 5'd0 || data_out !== prev || rd_valid !== 1'b0) begin bad++; $display("FAIL udf_hold: got c=%0d d=%0h v=%b want 0 %0h 0", count, data_out, rd_valid, prev); end
        cyc(1'b0, 1'b1, 8'h00, 1'b1);
        total++; if (underflow !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL err_priority: got udf=%b ovf=%b want 1 0", underflow, overflow); end
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL udf_clear: got %b want 0", underflow); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b1, 8'($urandom), 1'b0);
            total++; if (count !== 5'd8 || rd_valid !== 1'b1 || data_out !== exp_dout) begin bad++; $display("FAIL b2b[%0d]: got c=%0d v=%b d=%0h want 8 1 %0h", i, count, rd_valid, data_out, exp_dout); end
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 8'h00, 1'b0);
            total++; if (data_out !== exp_dout) begin bad++; $display("FAIL b2b_drain[%0d]: got %0h want %0h", i, data_out, exp_dout); end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty: got %b want 1", empty); end
    endtask

    task automatic test_ae_thresh();
        ae_thresh = 5'd4;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'($urandom), 1'b0);
        total++; if (almost_empty !== 1'b0) begin bad++; $display("FAIL ae_before: got %b want 0", almost_empty); end
        ae_thresh = 5'd6;
        #2;
        total++; if (almost_empty !== 1'b0) begin bad++; $display("FAIL ae_registered: got %b want 0", almost_empty); end
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL ae_after: got %b want 1", almost_empty); end
    endtask

    task automatic test_async_reset();
        while (mq.size() < 10) cyc(1'b1, 1'b0, 8'($urandom), 1'b0);
        total++; if (count !== 5'd10) begin bad++; $display("FAIL pre_rst_count: got %0d want 10", count); end
        #2 rst = 1'b1;
        #1;
        total++; if (empty !== 1'b1 || count !== 5'd0) begin bad++; $display("FAIL async_rst: got empty=%b c=%0d want 1 0", empty, count); end
        wr_en = 1'b1; data_in = 8'h77;
        @(posedge clk); #1;
        total++; if (count !== 5'd0) begin bad++; $display("FAIL rst_ignore_wr: got %0d want 0", count); end
        wr_en = 1'b0;
        @(negedge clk) rst = 1'b0;
        model_reset();
        cyc(1'b1, 1'b0, 8'h5C, 1'b0);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        total++; if (data_out !== 8'h5C || count !== 5'd0) begin bad++; $display("FAIL post_rst_word: got d=%0h c=%0d want 5c 0", data_out, count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) af_thresh = 5'($urandom_range(0, DEPTH));
            if ($urandom_range(0, 15) == 0) ae_thresh = 5'($urandom_range(0, DEPTH));
            cyc(1'($urandom_range(0, 99) < (i < 200 ? 65 : 35)), 1'($urandom_range(0, 99) < 50),
                8'($urandom), 1'($urandom_range(0, 19) == 0));
            total++; if (count !== 5'(mq.size())) begin bad++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, count, mq.size()); end
            total++; if (data_out !== exp_dout || rd_valid !== exp_valid) begin bad++; $display("FAIL rnd_read[%0d]: got d=%0h v=%b want %0h %b", i, data_out, rd_valid, exp_dout, exp_valid); end
            total++; if ({full, empty, almost_full, almost_empty} !==
                         {mq.size() == DEPTH, mq.size() == 0, mq.size() >= int'(af_thresh), mq.size() <= int'(ae_thresh)}) begin
                bad++; $display("FAIL rnd_flags[%0d]: got %b size=%0d af=%0d ae=%0d", i, {full, empty, almost_full, almost_empty}, mq.size(), af_thresh, ae_thresh);
            end
            total++; if ({overflow, underflow} !== {exp_ovf, exp_udf}) begin bad++; $display("FAIL rnd_err[%0d]: got %b want %b", i, {overflow, underflow}, {exp_ovf, exp_udf}); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_overflow_drain();
        test_underflow();
        test_back_to_back();
        test_ae_thresh();
        test_async_reset();
        af_thresh = 5'd12; ae_thresh = 5'd4;
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
